// File: rtl/fpu_wb_pkg.sv
// rtl/fpu_wb_pkg.sv - shared types for the FP result writeback path
package fpu_wb_pkg;

  localparam int FFLAGS_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int WB_TAG_W = 5;

  // Bit order matches the FPU status output: {NV,DZ,OF,UF,NX}
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    fflags_t              status;
    logic [WB_TAG_W-1:0]  tag;
  } wb_entry_t;

endpackage

// File: rtl/fpu_result_collector_if.sv
// rtl/fpu_result_collector_if.sv - FPU result input and register-file writeback channels
interface fpu_result_collector_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
);
  import fpu_wb_pkg::*;

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [WIDTH-1:0]     result_i;
  logic [FFLAGS_W-1:0]  status_i;
  logic [TAG_WIDTH-1:0] tag_i;
  logic                 wb_valid_o;
  logic                 wb_ready_i;
  logic [WIDTH-1:0]     wb_data_o;
  logic [TAG_WIDTH-1:0] wb_rd_o;

  modport slave (
    input  in_valid_i, result_i, status_i, tag_i, wb_ready_i,
    output in_ready_o, wb_valid_o, wb_data_o, wb_rd_o
  );

  modport master (
    output in_valid_i, result_i, status_i, tag_i, wb_ready_i,
    input  in_ready_o, wb_valid_o, wb_data_o, wb_rd_o
  );

endinterface

// File: rtl/fpu_wb_fifo.sv
// rtl/fpu_wb_fifo.sv - generic valid/ready FIFO with occupancy count and flush
module fpu_wb_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  input  T              push_data_i,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output T              pop_data_o,
  output logic [CW-1:0] count_o
);

  T              mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;

  // Ready depends only on registered occupancy, never on pop_ready_i
  assign push_ready_o = (count_q != CW'(DEPTH));
  assign pop_valid_o  = (count_q != '0);
  assign pop_data_o   = mem[rptr_q];
  assign count_o      = count_q;

  assign push = push_valid_i && push_ready_o && !flush_i;
  assign pop  = pop_valid_o && pop_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fpu_result_collector.sv
// rtl/fpu_result_collector.sv - buffers FPU results toward the register file and accrues fflags at commit
module fpu_result_collector
  import fpu_wb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  fpu_result_collector_if.slave  io,
  output fflags_t                fflags_o,
  input  logic                   fflags_clr_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   busy_o
);

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    fflags_t              status;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t in_entry, head;
  logic   pop;

  assign in_entry = '{data: io.result_i, status: fflags_t'(io.status_i), tag: io.tag_i};

  fpu_wb_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_valid_i (io.in_valid_i),
    .push_ready_o (io.in_ready_o),
    .push_data_i  (in_entry),
    .pop_valid_o  (io.wb_valid_o),
    .pop_ready_i  (io.wb_ready_i),
    .pop_data_o   (head),
    .count_o      (count_o)
  );

  // Storage is unreset, so the head is masked to zero while the FIFO is empty
  assign io.wb_data_o = io.wb_valid_o ? head.data : '0;
  assign io.wb_rd_o   = io.wb_valid_o ? head.tag  : '0;
  assign busy_o       = io.wb_valid_o;

  assign pop = io.wb_valid_o && io.wb_ready_i && !flush_i;

  // A clear coinciding with a commit keeps that commit's flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_o <= '0;
    end else if (fflags_clr_i) begin
      fflags_o <= pop ? head.status : '0;
    end else if (pop) begin
      fflags_o <= fflags_t'(fflags_o | head.status);
    end
  end

endmodule

// File: tb/tb_fpu_result_collector.sv
// tb/tb_fpu_result_collector.sv - directed vector bench for fpu_result_collector
module tb_fpu_result_collector;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic       fflags_clr_i = 1'b0;
  logic [4:0] fflags_o;
  logic [2:0] count_o;
  logic       busy_o;
  int         n_tests = 0;
  int         n_fail = 0;

  fpu_result_collector_if #(.WIDTH(32), .TAG_WIDTH(5)) io ();

  fpu_result_collector #(.WIDTH(32), .DEPTH(4), .TAG_WIDTH(5)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .io           (io),
    .fflags_o     (fflags_o),
    .fflags_clr_i (fflags_clr_i),
    .count_o      (count_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        fl, v;
    logic [31:0] d;
    logic [4:0]  st, tag;
    logic        rdy, clr;
    logic        ewv;
    logic [31:0] ed;
    logic [4:0]  erd;
    logic [2:0]  ecnt;
    logic        einr;
    logic [4:0]  eff;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic fl, logic v, logic [31:0] d, logic [4:0] st, logic [4:0] tag,
                              logic rdy, logic clr, logic ewv, logic [31:0] ed, logic [4:0] erd,
                              logic [2:0] ecnt, logic einr, logic [4:0] eff);
    vec_t r;
    r.fl = fl; r.v = v; r.d = d; r.st = st; r.tag = tag; r.rdy = rdy; r.clr = clr;
    r.ewv = ewv; r.ed = ed; r.erd = erd; r.ecnt = ecnt; r.einr = einr; r.eff = eff;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic v, input logic [31:0] d, input logic [4:0] st,
                       input logic [4:0] tag, input logic rdy, input logic clr);
    flush_i = fl;
    io.in_valid_i = v;
    io.result_i = d;
    io.status_i = st;
    io.tag_i = tag;
    io.wb_ready_i = rdy;
    fflags_clr_i = clr;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string nm, input logic [4:0] eff);
    chk({nm, " in_ready"}, 32'(io.in_ready_o), 32'd1);
    chk({nm, " wb_valid"}, 32'(io.wb_valid_o), 32'd0);
    chk({nm, " wb_data"}, io.wb_data_o, 32'd0);
    chk({nm, " wb_rd"}, 32'(io.wb_rd_o), 32'd0);
    chk({nm, " count"}, 32'(count_o), 32'd0);
    chk({nm, " busy"}, 32'(busy_o), 32'd0);
    chk({nm, " fflags"}, 32'(fflags_o), 32'(eff));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    // single entry held, then popped
    tbl.push_back(mk(0, 1, 32'h40000000, 5'b00000, 5'd3, 0, 0, 1, 32'h40000000, 5'd3, 3'd1, 1, 5'b00000));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40000000, 5'd3, 3'd1, 1, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 1, 5'b00000));
    // flag accrual at commit, clear alone, clear with commit
    tbl.push_back(mk(0, 1, 32'd1, 5'b00001, 5'd1, 0, 0, 1, 32'd1, 5'd1, 3'd1, 1, 5'b00000));
    tbl.push_back(mk(0, 1, 32'd2, 5'b10000, 5'd2, 1, 0, 1, 32'd2, 5'd2, 3'd1, 1, 5'b00001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 1, 5'b10001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 1, 5'b00000));
    tbl.push_back(mk(0, 1, 32'd3, 5'b00010, 5'd4, 0, 0, 1, 32'd3, 5'd4, 3'd1, 1, 5'b00000));
    tbl.push_back(mk(0, 1, 32'd6, 5'b00100, 5'd6, 1, 0, 1, 32'd6, 5'd6, 3'd1, 1, 5'b00010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3'd0, 1, 5'b00100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 5'b00100));

    repeat (2) cyc();
    chk_idle("reset", 5'b00000);
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].st, tbl[i].tag, tbl[i].rdy, tbl[i].clr);
      cyc();
      chk($sformatf("v%0d wb_valid", i), 32'(io.wb_valid_o), 32'(tbl[i].ewv));
      chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(tbl[i].ewv));
      chk($sformatf("v%0d count", i), 32'(count_o), 32'(tbl[i].ecnt));
      chk($sformatf("v%0d in_ready", i), 32'(io.in_ready_o), 32'(tbl[i].einr));
      chk($sformatf("v%0d fflags", i), 32'(fflags_o), 32'(tbl[i].eff));
      if (tbl[i].ewv) begin
        chk($sformatf("v%0d wb_data", i), io.wb_data_o, tbl[i].ed);
        chk($sformatf("v%0d wb_rd", i), 32'(io.wb_rd_o), 32'(tbl[i].erd));
      end
    end

    // fill to full, back-pressure a fifth result, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h100 + 32'(i), 0, 5'(i), 0, 0);
      cyc();
      chk($sformatf("fill%0d count", i), 32'(count_o), 32'(i + 1));
      chk($sformatf("fill%0d in_ready", i), 32'(io.in_ready_o), 32'(i < 3));
    end
    drive(0, 1, 32'h999, 0, 5'd9, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("full hold count", 32'(count_o), 32'd4);
      chk("full hold in_ready", 32'(io.in_ready_o), 32'd0);
      chk("full hold wb_rd", 32'(io.wb_rd_o), 32'd0);
    end
    io.wb_ready_i = 1'b1;
    cyc();
    chk("full pop count", 32'(count_o), 32'd3);
    chk("full pop in_ready", 32'(io.in_ready_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain%0d wb_valid", i), 32'(io.wb_valid_o), 32'd1);
      chk($sformatf("drain%0d wb_rd", i), 32'(io.wb_rd_o), 32'(i));
      chk($sformatf("drain%0d wb_data", i), io.wb_data_o, 32'h100 + 32'(i));
      io.wb_ready_i = 1'b1;
      cyc();
      io.wb_ready_i = 1'b0;
    end
    chk_idle("drained", 5'b00100);

    // back-to-back stream across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 32'h200 + 32'(i), 0, 5'(i), 1, 0);
      cyc();
      chk($sformatf("stream%0d wb_valid", i), 32'(io.wb_valid_o), 32'd1);
      chk($sformatf("stream%0d wb_data", i), io.wb_data_o, 32'h200 + 32'(i));
      chk($sformatf("stream%0d wb_rd", i), 32'(io.wb_rd_o), 32'(i));
      chk($sformatf("stream%0d count", i), 32'(count_o), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    cyc();
    chk_idle("stream end", 5'b00100);

    // flush with a concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h300 + 32'(i), 5'b11111, 5'(10 + i), 0, 0);
      cyc();
    end
    chk("pre-flush count", 32'(count_o), 32'd3);
    drive(1, 1, 32'h3ff, 5'b11111, 5'd31, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_idle("flush", 5'b00100);
    cyc();
    chk_idle("post-flush", 5'b00100);

    // asynchronous reset with entries held
    drive(0, 1, 32'h400, 5'b01000, 5'd1, 0, 0);
    cyc();
    drive(0, 1, 32'h401, 5'b00000, 5'd2, 0, 0);
    cyc();
    drive(0, 1, 32'h402, 5'b00000, 5'd3, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre-reset count", 32'(count_o), 32'd2);
    chk("pre-reset fflags", 32'(fflags_o), 32'b01100);
    #3 rst_ni = 1'b0;
    #1;
    chk_idle("async reset", 5'b00000);
    repeat (2) cyc();
    rst_ni = 1'b1;
    drive(0, 1, 32'h500, 5'b00000, 5'd7, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("resume wb_valid", 32'(io.wb_valid_o), 32'd1);
    chk("resume wb_data", io.wb_data_o, 32'h500);
    chk("resume wb_rd", 32'(io.wb_rd_o), 32'd7);
    chk("resume count", 32'(count_o), 32'd1);
    io.wb_ready_i = 1'b1;
    cyc();
    io.wb_ready_i = 1'b0;
    chk_idle("resume drained", 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_result_collector.md
Name: fpu_result_collector

Overview:
- Result-side counterpart of the FP unit input handshake.
- Sinks the fpnew_fma output channel: out_valid_o/out_ready_i, result_o, status_o, tag_o.
- Buffers results in a small FIFO and presents them on a writeback valid/ready port toward the FP register file.
- Accrues sticky IEEE exception flags (fflags) as results are committed.

Parameters:
- WIDTH, 32, result data width; equals fpnew_pkg::fp_width of the unit's format.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAG_WIDTH, 5, tag width; carries the destination register index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop all buffered results
- in_valid_i  in  1  result valid (from FPU out_valid_o)
- in_ready_o  out  1  ready to accept (to FPU out_ready_i)
- result_i  in  WIDTH  result data
- status_i  in  5  fpnew_pkg::status_t {NV,DZ,OF,UF,NX}
- tag_i  in  TAG_WIDTH  destination register tag
- wb_valid_o  out  1  writeback entry valid
- wb_ready_i  in  1  register file accepts entry
- wb_data_o  out  WIDTH  head-entry data
- wb_rd_o  out  TAG_WIDTH  head-entry tag
- fflags_o  out  5  sticky accrued flags
- fflags_clr_i  in  1  clear fflags (CSR write)
- count_o  out  $clog2(DEPTH)+1  occupancy
- busy_o  out  1  occupancy nonzero

Behaviour:
Reset values:
- Asynchronous reset, active low.
- All outputs 0 except in_ready_o, which is 1.
- Pointers and count are 0; FIFO storage is not reset.

Push and pop:
- Push when in_valid_i && in_ready_o; the entry stored is {result_i, status_i, tag_i}.
- in_ready_o = (count != DEPTH). It is derived from registered state only, with no combinational path from wb_ready_i.
- Pop when wb_valid_o && wb_ready_i.
- wb_valid_o = (count != 0).
- wb_data_o and wb_rd_o show the head entry and stay stable while wb_valid_o && !wb_ready_i.

Latency:
- An entry pushed in cycle N is visible on the wb port in cycle N+1.
- The FIFO is not bypassed into the same cycle.

Simultaneous push and pop:
- Allowed whenever both handshakes fire; count is unchanged.
- When full, in_ready_o = 0, so no push can occur even if a pop happens that cycle.
- When empty, a push is accepted; a pop cannot occur that cycle.

Pointers:
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count tracks occupancy, range 0..DEPTH.

fflags:
- On each pop, fflags_o |= head.status. Flags accrue at commit, not at accept.
- fflags_clr_i with no pop that cycle: fflags_o becomes 0.
- fflags_clr_i with a pop that cycle: fflags_o becomes head.status (the new flags survive).

flush_i:
- Next cycle: count = 0, pointers = 0, wb_valid_o = 0.
- A push in the same cycle is discarded.
- A pop in the same cycle does not accrue flags.
- fflags_o is otherwise unaffected.

Reset mid-operation:
- Immediate: all entries are lost and fflags_o becomes 0.

No state machine beyond FIFO occupancy: EMPTY (count 0), PARTIAL, FULL (count DEPTH).

Decomposition:
- Package fpu_wb_pkg:
  - fflags_t, 5-bit packed {NV,DZ,OF,UF,NX}, matching fpnew_pkg::status_t ordering.
  - wb_entry_t struct {data, status, tag}.
  - Constant FFLAGS_W = 5.
- Sub-module fpu_wb_fifo:
  - Generic valid/ready FIFO, parameterised on entry type and DEPTH.
  - Provides count_o and flush.
- fpu_result_collector instantiates fpu_wb_fifo and adds the fflags accrual logic.

Test Plan:
1. After reset, drive one push {0x40000000, status 0, tag 3} with wb_ready_i = 0 -> wb_valid_o = 1 next cycle, wb_data_o = 0x40000000, wb_rd_o = 3, count_o = 1. The entry is held stable 5 cycles; then wb_ready_i = 1 -> popped, count_o = 0, fflags_o = 0.
2. Push 4 entries with wb_ready_i = 0 -> in_ready_o = 0 after the 4th push, count_o = 4. A 5th in_valid_i is held and not accepted. Pulse wb_ready_i once -> in_ready_o = 1 the next cycle; entries pop in order with tags 0,1,2,3.
3. Stream 10 back-to-back entries with wb_ready_i = 1 -> the wb port delivers one per cycle from cycle 2 on with correct wrap-around, data order preserved, and count_o never exceeds 1.
4. Push status 5'b00001 (NX) then 5'b10000 (NV) and pop both -> fflags_o = 5'b10001. Assert fflags_clr_i alone -> 0. Assert fflags_clr_i in the same cycle as popping an entry with status 5'b00100 (OF) -> fflags_o = 5'b00100.
5. Fill 3 entries, then assert flush_i together with in_valid_i -> count_o = 0 and wb_valid_o = 0 next cycle, the pushed entry is absent, and fflags_o is unchanged.
6. With 2 entries held, deassert rst_ni mid-cycle -> outputs immediately at reset values (in_ready_o = 1, count_o = 0, fflags_o = 0). After release, normal operation resumes.
